// File: rtl/sw_scoring_engine.sv
// Smith-Waterman scoring engine: systolic PE array with config/target/result handshakes.
// Latency: result valid query_len+3 cycles after the last accepted target base.
// Backpressure: tgt_ready only in STREAM; result held stable until res_ready.
// Optional SW_SCORE_POS_EN adds res_tpos (target index of the best score).

module SW_ProcessingElement #(
   parameter int                     SCORE_WIDTH = 12,
   parameter logic [SCORE_WIDTH-1:0] ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_in,
   input  logic [1:0]             data_in,
   input  logic [1:0]             query,
   input  logic [SCORE_WIDTH-1:0] match,
   input  logic [SCORE_WIDTH-1:0] mismatch,
   input  logic [SCORE_WIDTH-1:0] gap_open,
   input  logic [SCORE_WIDTH-1:0] gap_extend,
   input  logic [SCORE_WIDTH-1:0] score_in,
   input  logic [SCORE_WIDTH-1:0] f_in,
   input  logic [SCORE_WIDTH-1:0] high_in,
   output logic                   en_out,
   output logic [1:0]             data_out,
   output logic [SCORE_WIDTH-1:0] score_out,
   output logic [SCORE_WIDTH-1:0] f_out,
   output logic [SCORE_WIDTH-1:0] high_out
);
   // LUT values are two's-complement deltas added to biased scores; compares are unsigned.
   function automatic logic [SCORE_WIDTH-1:0] smax(input logic [SCORE_WIDTH-1:0] a, input logic [SCORE_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [SCORE_WIDTH-1:0] diag, e_q, e_new, f_new, h_new, d_sc;

   // Cell recurrence: diagonal score, gap along target (e) and along query (f), floored at ZERO.
   always_comb begin
      d_sc  = diag + ((data_in == query) ? match : mismatch);
      e_new = smax(score_out + gap_open, e_q + gap_extend);
      f_new = smax(score_in + gap_open, f_in + gap_extend);
      h_new = smax(smax(ZERO, d_sc), smax(e_new, f_new));
   end

   // Cell state advances only when a target base passes through; high carries the running max down the array.
   always_ff @(posedge clk) begin
      if (!rst) begin
         en_out    <= 1'b0;
         data_out  <= 2'b00;
         diag      <= ZERO;
         e_q       <= ZERO;
         score_out <= ZERO;
         f_out     <= ZERO;
         high_out  <= ZERO;
      end else begin
         en_out   <= en_in;
         data_out <= data_in;
         if (en_in) begin
            diag      <= score_in;
            e_q       <= e_new;
            score_out <= h_new;
            f_out     <= f_new;
            high_out  <= smax(high_out, smax(h_new, high_in));
         end
      end
   end
endmodule

module sw_scoring_engine #(
   parameter int                     SCORE_WIDTH = 12,
   parameter int                     LENGTH      = 128,
   parameter int                     LOG_LENGTH  = $clog2(LENGTH),
   parameter int                     CNT_WIDTH   = 16,
   parameter logic [SCORE_WIDTH-1:0] ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [2*LENGTH-1:0]    query,
   input  logic [LOG_LENGTH-1:0]  query_len,
   input  logic [SCORE_WIDTH-1:0] match,
   input  logic [SCORE_WIDTH-1:0] mismatch,
   input  logic [SCORE_WIDTH-1:0] gap_open,
   input  logic [SCORE_WIDTH-1:0] gap_extend,
   input  logic                   tgt_valid,
   output logic                   tgt_ready,
   input  logic [1:0]             tgt_base,
   input  logic                   tgt_last,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [SCORE_WIDTH-1:0] result,
   output logic [CNT_WIDTH-1:0]   res_tlen,
   output logic                   res_err
`ifdef SW_SCORE_POS_EN
   ,
   output logic [CNT_WIDTH-1:0]   res_tpos
`endif
);
   typedef enum logic [2:0] {IDLE, STREAM, DRAIN, DONE, CLEAR} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                   state;
   logic [2*LENGTH-1:0]      query_q;
   logic [LOG_LENGTH-1:0]    qlen_q;
   logic [SCORE_WIDTH-1:0]   match_q, mismatch_q, gap_open_q, gap_extend_q;
   logic [CNT_WIDTH-1:0]     cnt;
   logic [LOG_LENGTH:0]      dcnt;
   logic                     started;

   logic                     accept, pe_rst;
   logic [SCORE_WIDTH-1:0]   high_sel;
   logic                     en_    [LENGTH+1];
   logic [1:0]               data_  [LENGTH+1];
   logic [SCORE_WIDTH-1:0]   score_ [LENGTH+1];
   logic [SCORE_WIDTH-1:0]   f_     [LENGTH+1];
   logic [SCORE_WIDTH-1:0]   high_  [LENGTH+1];

   // PE chain: index 0 is the array input, index i+1 is the output of PE i.
   assign accept    = tgt_valid & tgt_ready;
   assign pe_rst    = rst & (state != CLEAR);
   assign en_[0]    = accept;
   assign data_[0]  = tgt_base;
   assign score_[0] = ZERO;
   assign f_[0]     = ZERO;
   assign high_[0]  = ZERO;
   assign high_sel  = high_[qlen_q];

   for (genvar i = 0; i < LENGTH; i++) begin : g_pe
      SW_ProcessingElement #(.SCORE_WIDTH(SCORE_WIDTH), .ZERO(ZERO)) u_pe (
         .clk(clk), .rst(pe_rst), .en_in(en_[i]), .data_in(data_[i]), .query(query_q[2*i +: 2]),
         .match(match_q), .mismatch(mismatch_q), .gap_open(gap_open_q), .gap_extend(gap_extend_q),
         .score_in(score_[i]), .f_in(f_[i]), .high_in(high_[i]),
         .en_out(en_[i+1]), .data_out(data_[i+1]), .score_out(score_[i+1]), .f_out(f_[i+1]), .high_out(high_[i+1])
      );
   end

   // Job control FSM: config latch, target streaming, fixed-length drain, result hold, array clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cfg_ready    <= 1'b1;
         tgt_ready    <= 1'b0;
         res_valid    <= 1'b0;
         result       <= ZERO;
         res_tlen     <= '0;
         res_err      <= 1'b0;
         query_q      <= '0;
         qlen_q       <= '0;
         match_q      <= '0;
         mismatch_q   <= '0;
         gap_open_q   <= '0;
         gap_extend_q <= '0;
         cnt          <= '0;
         dcnt         <= '0;
         started      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cfg_valid) begin
               query_q      <= query;
               qlen_q       <= query_len;
               match_q      <= match;
               mismatch_q   <= mismatch;
               gap_open_q   <= gap_open;
               gap_extend_q <= gap_extend;
               cfg_ready    <= 1'b0;
               cnt          <= '0;
               started      <= 1'b0;
               if (query_len == '0) begin
                  result    <= ZERO;
                  res_tlen  <= '0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  tgt_ready <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (accept) begin
                  started <= 1'b1;
                  if (cnt == CNT_MAX) res_err <= 1'b1;
                  else                cnt     <= cnt + 1'b1;
                  if (tgt_last) begin
                     tgt_ready <= 1'b0;
                     dcnt      <= {1'b0, qlen_q} + 1'b1;
                     state     <= DRAIN;
                  end
               end else if (started) begin
                  // bubble mid-stream: stop scoring but still report the partial score
                  res_err   <= 1'b1;
                  tgt_ready <= 1'b0;
                  dcnt      <= {1'b0, qlen_q} + 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (dcnt == '0) begin
                  result    <= high_sel;
                  res_tlen  <= cnt;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  dcnt <= dcnt - 1'b1;
               end
            end
            DONE: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= CLEAR;
            end
            CLEAR: begin
               res_err   <= 1'b0;
               cnt       <= '0;
               started   <= 1'b0;
               cfg_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SW_SCORE_POS_EN
   logic [LOG_LENGTH-1:0]  idx_last;
   logic [CNT_WIDTH-1:0]   pe_cnt, tpos_run;
   logic [SCORE_WIDTH-1:0] hi_q;
   logic                   last_en_q;

   assign idx_last = qlen_q - 1'b1;

   // Track which target base, as seen by the last active PE, produced the last strict rise of the best score.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pe_cnt    <= '0;
         tpos_run  <= '0;
         hi_q      <= ZERO;
         last_en_q <= 1'b0;
         res_tpos  <= '0;
      end else if (state == IDLE && cfg_valid) begin
         pe_cnt    <= '0;
         tpos_run  <= '0;
         hi_q      <= ZERO;
         last_en_q <= 1'b0;
         res_tpos  <= '0;
      end else if (state == STREAM || state == DRAIN) begin
         last_en_q <= en_[idx_last];
         if (en_[idx_last]) pe_cnt <= pe_cnt + 1'b1;
         if (last_en_q && high_sel > hi_q) begin
            hi_q     <= high_sel;
            tpos_run <= pe_cnt - 1'b1;
         end
         if (state == DRAIN && dcnt == '0) res_tpos <= tpos_run;
      end
   end
`endif
endmodule

// File: tb/tb_sw_scoring_engine.sv
// Directed + random jobs against sw_scoring_engine (LENGTH=8) with an affine-gap SW reference model.
// Expected results are queued at stimulus time and popped when the result handshake appears.
// All waits on the DUT are cycle-bounded.

module tb_sw_scoring_engine;
   localparam int SW = 12, LEN = 8, LL = 3, CW = 16, ZERO = 2048;
   localparam int M = 2, MM = -1, GO = -3, GE = -1;

   logic            clk = 1'b0, rst = 1'b0;
   logic            cfg_valid = 1'b0, cfg_ready;
   logic [2*LEN-1:0] query = '0;
   logic [LL-1:0]   query_len = '0;
   logic [SW-1:0]   match = '0, mismatch = '0, gap_open = '0, gap_extend = '0;
   logic            tgt_valid = 1'b0, tgt_ready, tgt_last = 1'b0;
   logic [1:0]      tgt_base = '0;
   logic            res_valid, res_ready = 1'b0, res_err;
   logic [SW-1:0]   result;
   logic [CW-1:0]   res_tlen;
`ifdef SW_SCORE_POS_EN
   logic [CW-1:0]   res_tpos;
`endif

   sw_scoring_engine #(.SCORE_WIDTH(SW), .LENGTH(LEN), .LOG_LENGTH(LL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .query(query), .query_len(query_len),
      .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
      .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_base(tgt_base), .tgt_last(tgt_last),
      .res_valid(res_valid), .res_ready(res_ready), .result(result), .res_tlen(res_tlen), .res_err(res_err)
`ifdef SW_SCORE_POS_EN
      , .res_tpos(res_tpos)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int res; int tlen; int err; int tpos; } exp_t;
   exp_t sb[$];
   int   n_checks = 0, n_fail = 0;
   logic [1:0] qa [LEN];
   logic [1:0] ta [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] enc(input byte c);
      case (c)
         "A": return 2'b10;
         "G": return 2'b11;
         "T": return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   task automatic set_q(input string s);
      for (int i = 0; i < s.len(); i++) qa[i] = enc(s[i]);
   endtask

   task automatic set_t(input string s);
      for (int i = 0; i < s.len(); i++) ta[i] = enc(s[i]);
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Column-by-column affine-gap local alignment; tpos is the target index of the last strict rise of the best score.
   task automatic model(input int qlen, input int tlen, output int res, output int tpos);
      int hprev[LEN], eprev[LEN], hcur[LEN];
      int best, f, hup, d, e, h, s;
      best = 0; tpos = 0;
      for (int i = 0; i < LEN; i++) begin hprev[i] = 0; eprev[i] = -1000; hcur[i] = 0; end
      for (int j = 0; j < tlen; j++) begin
         f = -1000; hup = 0;
         for (int i = 0; i < qlen; i++) begin
            s = (qa[i] == ta[j]) ? M : MM;
            d = ((i == 0) ? 0 : hprev[i-1]) + s;
            e = max2(hprev[i] + GO, eprev[i] + GE);
            f = max2(hup + GO, f + GE);
            h = max2(max2(0, d), max2(e, f));
            hcur[i] = h; eprev[i] = e; hup = h;
            if (h > best) begin best = h; tpos = j; end
         end
         for (int i = 0; i < LEN; i++) hprev[i] = hcur[i];
      end
      res = ZERO + best;
   endtask

   task automatic send_cfg(input string tag, input int qlen);
      int k = 0;
      @(negedge clk);
      cfg_valid = 1'b1;
      for (int i = 0; i < LEN; i++) query[2*i +: 2] = qa[i];
      query_len  = qlen[LL-1:0];
      match      = SW'(M);
      mismatch   = SW'(MM);
      gap_open   = SW'(GO);
      gap_extend = SW'(GE);
      while (cfg_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) check({tag, "_cfg_timeout"}, k, 0);
      @(negedge clk);
      // scramble config inputs: the engine must have latched them
      cfg_valid  = 1'b0;
      query      = 16'($urandom);
      query_len  = 3'($urandom);
      match      = 12'($urandom);
      mismatch   = 12'($urandom);
      gap_open   = 12'($urandom);
      gap_extend = 12'($urandom);
   endtask

   task automatic send_beats(input string tag, input int n, input bit last);
      int k;
      for (int b = 0; b < n; b++) begin
         tgt_valid = 1'b1;
         tgt_base  = ta[b];
         tgt_last  = last && (b == n - 1);
         k = 0;
         while (tgt_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
         if (k >= 50) check({tag, "_tgt_timeout"}, k, 0);
         @(negedge clk);
      end
      tgt_valid = 1'b0;
      tgt_last  = 1'b0;
      tgt_base  = 2'($urandom);
   endtask

   task automatic get_result(input string tag, input int hold, output int waited, output int saw_tr);
      exp_t e;
      waited = 0; saw_tr = 0;
      while (res_valid !== 1'b1 && waited < 200) begin
         if (tgt_ready === 1'b1) saw_tr = 1;
         @(negedge clk); waited++;
      end
      if (tgt_ready === 1'b1) saw_tr = 1;
      check({tag, "_res_valid"}, res_valid, 1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, sb.size(), 1);
         return;
      end
      e = sb.pop_front();
      for (int c = 0; c < hold; c++) begin
         check({tag, "_hold_valid"}, res_valid, 1);
         check({tag, "_hold_res"}, result, e.res);
         check({tag, "_hold_tlen"}, res_tlen, e.tlen);
         @(negedge clk);
      end
      check({tag, "_res"}, result, e.res);
      check({tag, "_tlen"}, res_tlen, e.tlen);
      check({tag, "_err"}, res_err, e.err);
`ifdef SW_SCORE_POS_EN
      check({tag, "_tpos"}, res_tpos, e.tpos);
`endif
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, res_valid, 0);
   endtask

   // Expected values: exp_res < 0 selects the reference model; bubble jobs (last=0) flag an error.
   task automatic run_job(input string tag, input int qlen, input int nb, input bit last,
                          input int exp_res, input int exp_tpos, input int hold);
      exp_t e;
      int   mr, mt, waited, saw_tr;
      if (exp_res < 0) begin
         model(qlen, nb, mr, mt);
         e.res = mr; e.tpos = mt;
      end else begin
         e.res = exp_res; e.tpos = exp_tpos;
      end
      e.tlen = nb;
      e.err  = (!last || qlen == 0) ? 1 : 0;
      sb.push_back(e);
      send_cfg(tag, qlen);
      send_beats(tag, nb, last);
      get_result(tag, hold, waited, saw_tr);
      if (qlen == 0) begin
         check({tag, "_fast"}, (waited <= 2), 1);
         check({tag, "_no_tgt_ready"}, saw_tr, 0);
      end
   endtask

   initial begin
      int seen, ql, tl;
      repeat (3) @(negedge clk);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_tgt_ready", tgt_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_result", result, ZERO);
      check("rst_tlen", res_tlen, 0);
      check("rst_err", res_err, 0);
      rst = 1'b1;
      @(negedge clk);

      set_q("ACGT"); set_t("ACGT");
      run_job("acgt_acgt", 4, 4, 1'b1, ZERO + 4*M, 3, 0);
      // query holds one T, so a T-only target still scores a single match
      set_t("TTTT");
      run_job("acgt_tttt", 4, 4, 1'b1, ZERO + M, 0, 0);
      set_q("AAAA"); set_t("CCCC");
      run_job("nomatch", 4, 4, 1'b1, ZERO, 0, 0);
      run_job("qlen0", 0, 0, 1'b1, ZERO, 0, 0);
      set_q("ACGT"); set_t("ACGT");
      run_job("bubble", 4, 2, 1'b0, ZERO + 2*M, 1, 0);
      run_job("hold", 4, 4, 1'b1, ZERO + 4*M, 3, 10);
      set_t("TTTT");
      run_job("after_clear", 4, 4, 1'b1, ZERO + M, 0, 0);
      set_t("ACCGT");
      run_job("gap", 4, 5, 1'b1, ZERO + 6, 4, 0);
      set_t("GGACGT");
      run_job("ggacgt", 4, 6, 1'b1, ZERO + 4*M, 5, 0);

      // reset while streaming aborts the job with no result
      set_t("ACGT");
      send_cfg("midrst", 4);
      tgt_valid = 1'b1; tgt_base = ta[0];
      @(negedge clk);
      tgt_base = ta[1];
      @(negedge clk);
      rst = 1'b0; tgt_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_cfg_ready", cfg_ready, 1);
      check("midrst_tgt_ready", tgt_ready, 0);
      check("midrst_res_valid", res_valid, 0);
      seen = 0;
      repeat (20) begin @(negedge clk); if (res_valid === 1'b1) seen = 1; end
      check("midrst_no_result", seen, 0);
      run_job("post_rst", 4, 4, 1'b1, ZERO + 4*M, 3, 0);

      // random jobs, including the shortest and longest legal query
      for (int r = 0; r < 6; r++) begin
         ql = (r == 0) ? 1 : (r == 1) ? LEN - 1 : $urandom_range(LEN - 1, 1);
         tl = $urandom_range(20, 1);
         for (int i = 0; i < LEN; i++) qa[i] = 2'($urandom);
         for (int i = 0; i < 32; i++) ta[i] = 2'($urandom);
         run_job("rand", ql, tl, 1'b1, -1, 0, 0);
      end

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
